bw_io_impctl_above_filt: RTL and testbench

//  Upstream conditioning stage of the impedance-control loop. Synchronises the
//  raw comparator output (above) of the replica pad and integrates it over a

---
 rtl/bw_io_impctl_pkg.sv | 21 ++
 rtl/bw_io_impctl_above_filt_if.sv | 28 ++
 rtl/bw_u1_syncff_2x.sv | 26 ++
 rtl/bw_io_impctl_above_filt.sv | 161 ++++++++++++++++
 tb/tb_bw_io_impctl_above_filt.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bw_io_impctl_pkg.sv
// Shared definitions for the impedance-control loop.
//  - filt_state_e : state encoding of the comparator filter FSM
//  - *_DEF        : default window size, settle delay and dead-band thresholds,
//                   also used by the impctl state machine block
package bw_io_impctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_ACCUM    = 3'd2,
    ST_DECIDE   = 3'd3,
    ST_WAIT_ACK = 3'd4
  } filt_state_e;

  localparam int NSAMP_DEF  = 8;
  localparam int CNT_W_DEF  = 4;   // log2(NSAMP_DEF)+1, spare bit so a full window never wraps
  localparam int SETTLE_DEF = 3;
  localparam int THR_HI_DEF = 6;
  localparam int THR_LO_DEF = 2;

endpackage

// File: rtl/bw_io_impctl_above_filt_if.sv
// Bus between the comparator filter and its surroundings.
//  master : drives above_raw, code_chg, bypass, req_ack; observes results
//  slave  : the filter; drives inc, dec, hold, ones_cnt, above_sync
interface bw_io_impctl_above_filt_if
  import bw_io_impctl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             above_raw;
  logic             code_chg;
  logic             bypass;
  logic             req_ack;
  logic             inc;
  logic             dec;
  logic             hold;
  logic [CNT_W-1:0] ones_cnt;
  logic             above_sync;

  modport master (
    output above_raw, code_chg, bypass, req_ack,
    input  inc, dec, hold, ones_cnt, above_sync
  );

  modport slave (
    input  above_raw, code_chg, bypass, req_ack,
    output inc, dec, hold, ones_cnt, above_sync
  );
endinterface

// File: rtl/bw_u1_syncff_2x.sv
// Two-flop synchroniser with asynchronous active-low reset.
//  clk   : destination clock
//  rst_n : asynchronous reset, active low, clears both stages
//  d     : asynchronous input
//  q     : synchronised output, two clk cycles behind d
module bw_u1_syncff_2x (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/bw_io_impctl_above_filt.sv
// Comparator conditioning stage of the impedance-control loop.
// Synchronises the replica-pad comparator, waits SETTLE cycles after each code
// change, counts ones over an NSAMP window and issues one inc/dec request
// (held until req_ack) or a one-cycle hold pulse when inside the dead band.
//  rclk         : clock
//  hard_reset_n : asynchronous active-low reset
//  bus          : slave side of bw_io_impctl_above_filt_if
//                 (above_raw, code_chg, bypass, req_ack in;
//                  inc, dec, hold, ones_cnt, above_sync out)
module bw_io_impctl_above_filt
  import bw_io_impctl_pkg::*;
#(
  parameter int NSAMP  = NSAMP_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int THR_HI = THR_HI_DEF,
  parameter int THR_LO = THR_LO_DEF
) (
  input  logic                     rclk,
  input  logic                     hard_reset_n,
  bw_io_impctl_above_filt_if.slave bus
);
  localparam int               SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] SAMP_LAST   = CNT_W'(NSAMP - 1);
  localparam logic [CNT_W-1:0] ONES_MAX    = CNT_W'(NSAMP);
  localparam logic [CNT_W-1:0] THR_HI_C    = CNT_W'(THR_HI);
  localparam logic [CNT_W-1:0] THR_LO_C    = CNT_W'(THR_LO);

  logic above_sync;

  filt_state_e      state_reg,  state_next;
  logic [SET_W-1:0] settle_reg, settle_next;
  logic [CNT_W-1:0] sample_reg, sample_next;
  logic [CNT_W-1:0] ones_reg,   ones_next;
  logic             inc_reg,    inc_next;
  logic             dec_reg,    dec_next;
  logic             hold_reg,   hold_next;

  bw_u1_syncff_2x u_sync (
    .clk   (rclk),
    .rst_n (hard_reset_n),
    .d     (bus.above_raw),
    .q     (above_sync)
  );

  always_ff @(posedge rclk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_reg  <= ST_SETTLE;
      settle_reg <= '0;
      sample_reg <= '0;
      ones_reg   <= '0;
      inc_reg    <= 1'b0;
      dec_reg    <= 1'b0;
      hold_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      sample_reg <= sample_next;
      ones_reg   <= ones_next;
      inc_reg    <= inc_next;
      dec_reg    <= dec_next;
      hold_reg   <= hold_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    sample_next = sample_reg;
    ones_next   = ones_reg;
    inc_next    = inc_reg;
    dec_next    = dec_reg;
    hold_next   = 1'b0;

    if (bus.bypass) begin
      // Frozen loop: everything parked at zero until bypass drops.
      state_next  = ST_IDLE;
      settle_next = '0;
      sample_next = '0;
      ones_next   = '0;
      inc_next    = 1'b0;
      dec_next    = 1'b0;
    end else if (state_reg == ST_IDLE) begin
      // IDLE is only reachable through bypass, so being here with bypass
      // low means bypass just fell.
      state_next  = ST_SETTLE;
      settle_next = '0;
      sample_next = '0;
      ones_next   = '0;
    end else if (bus.code_chg) begin
      // A new code invalidates the window and any pending request, even one
      // being acknowledged in this same cycle.
      state_next  = ST_SETTLE;
      settle_next = '0;
      sample_next = '0;
      ones_next   = '0;
      inc_next    = 1'b0;
      dec_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (settle_reg == SETTLE_LAST) begin
            state_next  = ST_ACCUM;
            settle_next = '0;
          end else begin
            settle_next = settle_reg + SET_W'(1);
          end
        end
        ST_ACCUM: begin
          sample_next = sample_reg + CNT_W'(1);
          ones_next   = (ones_reg == ONES_MAX) ? ones_reg : ones_reg + CNT_W'(above_sync);
          if (sample_reg == SAMP_LAST) begin
            state_next = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (ones_reg >= THR_HI_C) begin
            inc_next   = 1'b1;
            state_next = ST_WAIT_ACK;
          end else if (ones_reg <= THR_LO_C) begin
            dec_next   = 1'b1;
            state_next = ST_WAIT_ACK;
          end else begin
            // Dead band: no code step, just start another window straight
            // away since the replica has not changed.
            hold_next   = 1'b1;
            sample_next = '0;
            ones_next   = '0;
            state_next  = ST_ACCUM;
          end
        end
        ST_WAIT_ACK: begin
          if (bus.req_ack) begin
            inc_next    = 1'b0;
            dec_next    = 1'b0;
            settle_next = '0;
            sample_next = '0;
            ones_next   = '0;
            state_next  = ST_SETTLE;
          end
        end
        default: begin
          state_next  = ST_SETTLE;
          settle_next = '0;
          sample_next = '0;
          ones_next   = '0;
          inc_next    = 1'b0;
          dec_next    = 1'b0;
        end
      endcase
    end
  end

  assign bus.inc        = inc_reg;
  assign bus.dec        = dec_reg;
  assign bus.hold       = hold_reg;
  assign bus.ones_cnt   = ones_reg;
  assign bus.above_sync = above_sync;

endmodule

// File: tb/tb_bw_io_impctl_above_filt.sv
// Directed bench for bw_io_impctl_above_filt (NSAMP=8, SETTLE=3, THR 6/2).
// Inputs change just after the falling edge; outputs are sampled there too.
module tb_bw_io_impctl_above_filt;
  import bw_io_impctl_pkg::*;

  logic rclk = 1'b0;
  logic hard_reset_n = 1'b0;
  always #5 rclk = ~rclk;

  bw_io_impctl_above_filt_if #(.CNT_W(4)) bus ();

  bw_io_impctl_above_filt #(
    .NSAMP(8), .CNT_W(4), .SETTLE(3), .THR_HI(6), .THR_LO(2)
  ) dut (
    .rclk         (rclk),
    .hard_reset_n (hard_reset_n),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] pat;   // comparator value for each of the 8 samples
    int         ones;  // hand-counted ones in pat
    logic       inc;
    logic       dec;
    logic       hold;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance to the next falling edge and check the invariants.
  task automatic step();
    @(negedge rclk);
    check("inc_dec_exclusive", int'(bus.inc & bus.dec), 0);
    check("hold_vs_request", int'(bus.hold & (bus.inc | bus.dec)), 0);
  endtask

  // Bit j of stream is driven before the (j+1)-th clock edge from now.
  task automatic drive(input logic [31:0] stream, input int from, input int upto);
    for (int j = from; j < upto; j++) begin
      bus.above_raw = stream[j];
      step();
    end
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!(bus.inc || bus.dec) && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic ack(input string name);
    bus.req_ack = 1'b1;
    step();
    bus.req_ack = 1'b0;
    check({name, "_ack_drop"}, int'(bus.inc | bus.dec), 0);
  endtask

  initial begin
    int          n;
    int          bad_seen;
    logic [31:0] stream;

    vecs[0] = '{8'b1111_1110, 7, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'b0100_0001, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'b1010_0101, 4, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'b1111_1100, 6, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'b0000_0111, 3, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'b0001_1111, 5, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'b0000_0000, 0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'b1111_1111, 8, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'b0000_0100, 1, 1'b0, 1'b1, 1'b0};

    bus.above_raw = 1'b1;
    bus.code_chg  = 1'b0;
    bus.bypass    = 1'b0;
    bus.req_ack   = 1'b0;

    // Reset with the comparator high: nothing may leak through.
    repeat (3) @(negedge rclk);
    check("rst_inc", int'(bus.inc), 0);
    check("rst_dec", int'(bus.dec), 0);
    check("rst_hold", int'(bus.hold), 0);
    check("rst_ones", int'(bus.ones_cnt), 0);
    check("rst_above_sync", int'(bus.above_sync), 0);
    hard_reset_n = 1'b1;
    wait_req(n);
    check("rst_latency", n, 12);
    check("rst_first_inc", int'(bus.inc), 1);
    step();
    step();
    check("rst_inc_cycle14", int'(bus.inc), 1);
    $display("reset release: first request after %0d cycles inc=%0d", n, bus.inc);
    ack("rst");

    // Table: each row starts on the edge that entered SETTLE.
    for (int v = 0; v < 9; v++) begin
      stream = {23'b0, vecs[v].pat, 1'b0};
      drive(stream, 0, 11);
      check($sformatf("vec%0d_ones", v), int'(bus.ones_cnt), vecs[v].ones);
      drive(stream, 11, 12);
      check($sformatf("vec%0d_inc", v), int'(bus.inc), int'(vecs[v].inc));
      check($sformatf("vec%0d_dec", v), int'(bus.dec), int'(vecs[v].dec));
      check($sformatf("vec%0d_hold", v), int'(bus.hold), int'(vecs[v].hold));
      $display("vec %0d pat=%b ones=%0d -> inc=%0d dec=%0d hold=%0d",
               v, vecs[v].pat, vecs[v].ones, bus.inc, bus.dec, bus.hold);
      if (vecs[v].hold) begin
        check($sformatf("vec%0d_hold_clear", v), int'(bus.ones_cnt), 0);
        bus.code_chg = 1'b1;
        step();
        bus.code_chg = 1'b0;
        check($sformatf("vec%0d_hold_pulse", v), int'(bus.hold), 0);
      end else begin
        ack($sformatf("vec%0d", v));
      end
    end

    // Dead-band window followed directly by a fresh window of 7 ones.
    stream = {14'b0, 8'b0111_1111, 1'b0, 8'b0011_0011, 1'b0};
    drive(stream, 0, 12);
    check("hb_hold", int'(bus.hold), 1);
    check("hb_ones_clear", int'(bus.ones_cnt), 0);
    drive(stream, 12, 13);
    check("hb_hold_one_cycle", int'(bus.hold), 0);
    check("hb_new_window", int'(bus.ones_cnt), 1);
    drive(stream, 13, 20);
    check("hb_no_early_inc", int'(bus.inc), 0);
    drive(stream, 20, 21);
    check("hb_inc", int'(bus.inc), 1);
    check("hb_ones", int'(bus.ones_cnt), 7);
    $display("hold then new window: inc=%0d ones=%0d", bus.inc, bus.ones_cnt);

    // Request held 20 cycles without ack.
    bad_seen = 0;
    bus.above_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.inc !== 1'b1 || bus.dec !== 1'b0) bad_seen++;
    end
    check("inc_stable_20", bad_seen, 0);
    ack("stable");
    wait_req(n);
    check("post_ack_latency", n, 12);
    check("post_ack_inc", int'(bus.inc), 1);
    $display("hold 20 cycles then ack: next request after %0d cycles", n);

    // code_chg after 5 samples restarts settle and window.
    ack("pre_cc");
    repeat (8) step();
    check("cc_ones_at5", int'(bus.ones_cnt), 5);
    bus.code_chg = 1'b1;
    step();
    bus.code_chg = 1'b0;
    check("cc_ones_clear", int'(bus.ones_cnt), 0);
    wait_req(n);
    check("cc_latency", n, 12);
    check("cc_inc", int'(bus.inc), 1);
    $display("code_chg at sample 5: request after %0d cycles", n);

    // code_chg coincident with req_ack, then a stray req_ack mid-window.
    bus.code_chg = 1'b1;
    bus.req_ack  = 1'b1;
    step();
    bus.code_chg = 1'b0;
    bus.req_ack  = 1'b0;
    check("ccack_drop", int'(bus.inc | bus.dec), 0);
    repeat (5) step();
    bus.req_ack = 1'b1;
    step();
    bus.req_ack = 1'b0;
    wait_req(n);
    check("ccack_latency", n + 6, 12);
    $display("code_chg+req_ack: request after %0d cycles", n + 6);

    // bypass during WAIT_ACK.
    bus.bypass = 1'b1;
    step();
    check("byp_inc_drop", int'(bus.inc), 0);
    bad_seen = 0;
    for (int i = 0; i < 10; i++) begin
      bus.code_chg = (i == 3);
      bus.req_ack  = (i == 5);
      step();
      if (bus.inc || bus.dec || bus.hold || bus.ones_cnt != 4'd0) bad_seen++;
    end
    bus.code_chg = 1'b0;
    bus.req_ack  = 1'b0;
    check("byp_idle_quiet", bad_seen, 0);
    bus.bypass = 1'b0;
    step();
    wait_req(n);
    check("byp_release_latency", n, 12);
    check("byp_release_inc", int'(bus.inc), 1);
    $display("bypass release: request after %0d cycles", n);

    // Asynchronous reset off the clock edge while a request is pending.
    @(negedge rclk);
    #2;
    hard_reset_n = 1'b0;
    #1;
    check("async_rst_inc", int'(bus.inc), 0);
    check("async_rst_ones", int'(bus.ones_cnt), 0);
    check("async_rst_sync", int'(bus.above_sync), 0);
    $display("async reset mid WAIT_ACK: inc=%0d", bus.inc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
